// File: rtl/kamikaze_prefetch_if.sv
// Fetch-unit bus bundle: pipelined instruction-memory port plus the
// valid/ready instruction port towards decode.
interface kamikaze_prefetch_if;
  logic        im_req_o;
  logic [31:0] im_addr_o;
  logic        im_gnt_i;
  logic        im_rvalid_i;
  logic [31:0] im_data_i;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic        is_compressed_instr_o;
  logic [31:0] pc_o;

  modport master (
    output im_req_o, im_addr_o, instr_o, instr_valid_o, is_compressed_instr_o, pc_o,
    input  im_gnt_i, im_rvalid_i, im_data_i, instr_ready_i
  );

  modport slave (
    input  im_req_o, im_addr_o, instr_o, instr_valid_o, is_compressed_instr_o, pc_o,
    output im_gnt_i, im_rvalid_i, im_data_i, instr_ready_i
  );
endinterface

// File: rtl/kamikaze_prefetch.sv
// RV32/RV32C prefetch unit: credit-limited pipelined fetch into a halfword
// FIFO, with 16/32-bit realignment and redirect flush.
module kamikaze_prefetch #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 4,
  parameter bit          ENABLE_RVC = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                redirect_i,
  input  logic [31:0]         redirect_pc_i,
  kamikaze_prefetch_if.master bus
);
  localparam int HW = 2 * FIFO_DEPTH;
  localparam int PW = $clog2(HW);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  // Discards accumulate across back-to-back redirects, so leave headroom.
  localparam int DW = OW + 4;
  localparam logic [31:0] PC_MASK = ENABLE_RVC ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;

  logic [15:0]   r_fifo [HW];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [OW-1:0] r_outstanding;
  logic [DW-1:0] r_discard;
  logic          r_drop_low;
  logic [31:0]   r_pc;
  logic [31:0]   r_addr;

  logic [15:0]   w_h0;
  logic [15:0]   w_h1;
  logic          w_is_c;
  logic          w_valid;
  logic          w_fire;
  logic [1:0]    w_pop_n;
  logic [1:0]    w_push_n;
  logic [CW-1:0] w_free_words;
  logic          w_req;
  logic          w_grant;
  logic          w_resp_live;
  logic          w_resp_drop;
  logic          w_push;
  logic [OW-1:0] w_out_after;
  logic [DW-1:0] w_disc_after;

  always_comb begin
    w_h0         = r_fifo[r_rd_ptr];
    w_h1         = r_fifo[r_rd_ptr + PW'(1)];
    w_is_c       = ENABLE_RVC && (w_h0[1:0] != 2'b11);
    w_valid      = w_is_c ? (r_count >= CW'(1)) : (r_count >= CW'(2));
    w_pop_n      = w_is_c ? 2'd1 : 2'd2;
    w_fire       = w_valid && bus.instr_ready_i && !redirect_i;
    // Credit: whole free words not already promised to in-flight requests.
    w_free_words = (CW'(HW) - r_count) >> 1;
    w_req        = (w_free_words > CW'(r_outstanding)) && !redirect_i && !rst_i;
    w_grant      = w_req && bus.im_gnt_i;
    w_resp_drop  = bus.im_rvalid_i && (r_discard != '0);
    // A response with nothing outstanding belongs to a pre-reset grant.
    w_resp_live  = bus.im_rvalid_i && (r_discard == '0) && (r_outstanding != '0);
    w_push       = w_resp_live && !redirect_i;
    w_push_n     = r_drop_low ? 2'd1 : 2'd2;
    w_out_after  = r_outstanding + OW'(w_grant) - OW'(w_resp_live);
    w_disc_after = r_discard - DW'(w_resp_drop);
  end

  assign bus.im_req_o              = w_req;
  assign bus.im_addr_o             = r_addr;
  assign bus.instr_o               = w_is_c ? {16'h0000, w_h0} : {w_h1, w_h0};
  assign bus.instr_valid_o         = w_valid;
  assign bus.is_compressed_instr_o = w_is_c;
  assign bus.pc_o                  = r_pc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_drop_low    <= 1'b0;
      r_pc          <= RESET_PC & PC_MASK;
      r_addr        <= RESET_PC & 32'hFFFF_FFFC;
    end else if (redirect_i) begin
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= w_disc_after + DW'(w_out_after);
      r_drop_low    <= ENABLE_RVC && redirect_pc_i[1];
      r_pc          <= redirect_pc_i & PC_MASK;
      r_addr        <= redirect_pc_i & 32'hFFFF_FFFC;
    end else begin
      r_outstanding <= w_out_after;
      r_discard     <= w_disc_after;
      r_count       <= r_count + (w_push ? CW'(w_push_n) : CW'(0))
                               - (w_fire ? CW'(w_pop_n) : CW'(0));
      if (w_grant) begin
        r_addr <= r_addr + 32'd4;
      end
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + PW'(w_push_n);
        r_drop_low <= 1'b0;
      end
      if (w_fire) begin
        r_rd_ptr <= r_rd_ptr + PW'(w_pop_n);
        r_pc     <= r_pc + (w_is_c ? 32'd2 : 32'd4);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= r_drop_low ? bus.im_data_i[31:16] : bus.im_data_i[15:0];
      if (!r_drop_low) begin
        r_fifo[r_wr_ptr + PW'(1)] <= bus.im_data_i[31:16];
      end
    end
  end
endmodule

// File: tb/tb_kamikaze_prefetch.sv
// Bench for kamikaze_prefetch: RVC and non-RVC instances, in-order memory
// responders and an instruction-stream scoreboard built from the memory image.
module tb_kamikaze_prefetch;
  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        c;
  } exp_t;

  kamikaze_prefetch_if bus_a ();
  kamikaze_prefetch_if bus_b ();

  logic        rst_a = 1'b1, rst_b = 1'b1;
  logic        redir_a = 1'b0, redir_b = 1'b0;
  logic [31:0] rpc_a = '0, rpc_b = '0;

  int   errors = 0, checks = 0;
  int   lat_a = 0, lat_b = 1;
  int   cyc_a = 0, cyc_b = 0;
  bit   gnt_rand_a = 1'b0;
  bit   rdy_en_a = 1'b0, rdy_en_b = 1'b0;
  exp_t exp_a [$];
  exp_t exp_b [$];
  logic [31:0] pend_addr_a [$];
  int          pend_due_a  [$];
  logic [31:0] pend_addr_b [$];
  int          pend_due_b  [$];
  logic [31:0] mem [logic [31:0]];

  kamikaze_prefetch #(.RESET_PC(32'h0), .FIFO_DEPTH(4), .ENABLE_RVC(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .redirect_i(redir_a), .redirect_pc_i(rpc_a), .bus(bus_a)
  );
  kamikaze_prefetch #(.RESET_PC(32'h40), .FIFO_DEPTH(4), .ENABLE_RVC(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .redirect_i(redir_b), .redirect_pc_i(rpc_b), .bus(bus_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0000_0013;
  endfunction

  function automatic logic [15:0] half_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem_rd({a[31:2], 2'b00});
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Walk the memory image as an instruction stream and queue the expected fires.
  task automatic push_stream(input int which, input logic [31:0] start, input int n, input bit rvc);
    logic [31:0] pc;
    logic [15:0] h;
    exp_t e;
    pc = start;
    for (int i = 0; i < n; i++) begin
      h = half_at(pc);
      e.pc = pc;
      if (rvc && h[1:0] != 2'b11) begin
        e.instr = {16'h0000, h};
        e.c     = 1'b1;
        pc      = pc + 32'd2;
      end else begin
        e.instr = {half_at(pc + 32'd2), h};
        e.c     = 1'b0;
        pc      = pc + 32'd4;
      end
      if (which == 0) exp_a.push_back(e);
      else            exp_b.push_back(e);
    end
  endtask

  task automatic wait_drain(input int which, input string tag);
    int n;
    n = 0;
    while (((which == 0) ? exp_a.size() : exp_b.size()) > 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk(tag, (which == 0) ? exp_a.size() : exp_b.size(), 32'd0);
  endtask

  // Called just after a rising edge; the redirect is held for one cycle.
  task automatic redirect_a(input logic [31:0] target, input int n, input string tag);
    redir_a = 1'b1;
    rpc_a   = target;
    exp_a.delete();
    push_stream(0, target, n, 1'b1);
    @(posedge clk); #1;
    redir_a = 1'b0;
    @(negedge clk);
    chk({tag, "_pc"},    bus_a.pc_o, target & 32'hFFFF_FFFE);
    chk({tag, "_valid"}, {31'd0, bus_a.instr_valid_o}, 32'd0);
    chk({tag, "_req"},   {31'd0, bus_a.im_req_o}, 32'd1);
    chk({tag, "_addr"},  bus_a.im_addr_o, target & 32'hFFFF_FFFC);
  endtask

  // In-order memory responders with configurable latency.
  initial begin
    bus_a.im_gnt_i = 1'b0; bus_a.im_rvalid_i = 1'b0; bus_a.im_data_i = '0;
    forever begin
      @(posedge clk); #1;
      cyc_a++;
      if (rst_a) begin pend_addr_a.delete(); pend_due_a.delete(); end
      if (pend_due_a.size() > 0 && pend_due_a[0] <= cyc_a) begin
        bus_a.im_rvalid_i = 1'b1;
        bus_a.im_data_i   = mem_rd(pend_addr_a.pop_front());
        void'(pend_due_a.pop_front());
      end else begin
        bus_a.im_rvalid_i = 1'b0;
        bus_a.im_data_i   = 32'hDEAD_BEEF;
      end
      bus_a.im_gnt_i = gnt_rand_a ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (bus_a.im_req_o && bus_a.im_gnt_i && !rst_a) begin
        pend_addr_a.push_back(bus_a.im_addr_o);
        pend_due_a.push_back(cyc_a + 1 + lat_a);
      end
    end
  end

  initial begin
    bus_b.im_gnt_i = 1'b0; bus_b.im_rvalid_i = 1'b0; bus_b.im_data_i = '0;
    forever begin
      @(posedge clk); #1;
      cyc_b++;
      if (rst_b) begin pend_addr_b.delete(); pend_due_b.delete(); end
      if (pend_due_b.size() > 0 && pend_due_b[0] <= cyc_b) begin
        bus_b.im_rvalid_i = 1'b1;
        bus_b.im_data_i   = mem_rd(pend_addr_b.pop_front());
        void'(pend_due_b.pop_front());
      end else begin
        bus_b.im_rvalid_i = 1'b0;
        bus_b.im_data_i   = 32'hDEAD_BEEF;
      end
      bus_b.im_gnt_i = 1'b1;
      @(negedge clk);
      if (bus_b.im_req_o && bus_b.im_gnt_i && !rst_b) begin
        pend_addr_b.push_back(bus_b.im_addr_o);
        pend_due_b.push_back(cyc_b + 1 + lat_b);
      end
    end
  end

  // Decode side: ready only while expectations remain; every fire is scored.
  initial begin
    exp_t e;
    bus_a.instr_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      bus_a.instr_ready_i = rdy_en_a && (exp_a.size() > 0) && !rst_a;
      if (!rst_a && !redir_a && bus_a.instr_valid_o && bus_a.instr_ready_i) begin
        e = exp_a.pop_front();
        $display("A fire pc=%h instr=%h c=%0d", bus_a.pc_o, bus_a.instr_o, bus_a.is_compressed_instr_o);
        chk("a_instr", bus_a.instr_o, e.instr);
        chk("a_pc",    bus_a.pc_o, e.pc);
        chk("a_c",     {31'd0, bus_a.is_compressed_instr_o}, {31'd0, e.c});
      end
    end
  end

  initial begin
    exp_t e;
    bus_b.instr_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      bus_b.instr_ready_i = rdy_en_b && (exp_b.size() > 0) && !rst_b;
      if (!rst_b && !redir_b && bus_b.instr_valid_o && bus_b.instr_ready_i) begin
        e = exp_b.pop_front();
        $display("B fire pc=%h instr=%h c=%0d", bus_b.pc_o, bus_b.instr_o, bus_b.is_compressed_instr_o);
        chk("b_instr", bus_b.instr_o, e.instr);
        chk("b_pc",    bus_b.pc_o, e.pc);
        chk("b_c",     {31'd0, bus_b.is_compressed_instr_o}, {31'd0, e.c});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  found;
    mem[32'h200] = 32'h4501_4501;
    mem[32'h204] = 32'h0013_4501;
    mem[32'h208] = 32'h0001_0000;
    mem[32'h100] = 32'h4501_0000;
    mem[32'h300] = 32'h00A0_0093;
    mem[32'h304] = 32'h0010_0113;
    mem[32'h40]  = 32'h0000_4501;

    // Reset state of both instances.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("a_rst_req",   {31'd0, bus_a.im_req_o}, 32'd0);
    chk("a_rst_valid", {31'd0, bus_a.instr_valid_o}, 32'd0);
    chk("a_rst_pc",    bus_a.pc_o, 32'h0);
    chk("b_rst_pc",    bus_b.pc_o, 32'h40);
    chk("b_rst_req",   {31'd0, bus_b.im_req_o}, 32'd0);

    // 1: zero-wait stream of 32-bit NOPs from RESET_PC.
    @(posedge clk); #1;
    rst_a = 1'b0;
    push_stream(0, 32'h0, 8, 1'b1);
    rdy_en_a = 1'b1;
    @(negedge clk);
    chk("t1_first_req",  {31'd0, bus_a.im_req_o}, 32'd1);
    chk("t1_first_addr", bus_a.im_addr_o, 32'h0);
    chk("t1_no_valid",   {31'd0, bus_a.instr_valid_o}, 32'd0);
    wait_drain(0, "t1_drain");

    // 2: compressed pairs and a 32-bit instruction split across words.
    lat_a = 2; gnt_rand_a = 1'b1;
    @(posedge clk); #1;
    redirect_a(32'h200, 8, "t2");
    wait_drain(0, "t2_drain");

    // 3: decode stall; head must hold and requests stop once the FIFO is full.
    lat_a = 0; gnt_rand_a = 1'b0;
    @(posedge clk); #1;
    redirect_a(32'h400, 24, "t3");
    n = 0;
    while (exp_a.size() > 18 && n < 100) begin @(posedge clk); n++; end
    @(posedge clk); #1;
    rdy_en_a = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", {31'd0, bus_a.instr_valid_o}, 32'd1);
      chk("t3_hold_instr", bus_a.instr_o, exp_a[0].instr);
      chk("t3_hold_pc",    bus_a.pc_o, exp_a[0].pc);
    end
    chk("t3_req_off", {31'd0, bus_a.im_req_o}, 32'd0);
    @(posedge clk); #1;
    rdy_en_a = 1'b1;
    wait_drain(0, "t3_drain");

    // 4: redirect to an odd halfword with three requests in flight.
    lat_a = 6;
    @(posedge clk); #1;
    redirect_a(32'h600, 4, "t4a");
    n = 0;
    do begin @(posedge clk); #2; n++; end while (pend_addr_a.size() < 3 && n < 50);
    chk("t4_inflight", pend_addr_a.size(), 32'd3);
    redirect_a(32'h102, 6, "t4");
    wait_drain(0, "t4_drain");

    // 5: redirect coinciding with a fire and a returning word.
    lat_a = 0;
    @(posedge clk); #1;
    redirect_a(32'h700, 30, "t5a");
    found = 1'b0; n = 0;
    while (!found && n < 100) begin
      @(posedge clk); #2; n++;
      if (bus_a.im_rvalid_i && bus_a.instr_valid_o && bus_a.instr_ready_i) found = 1'b1;
    end
    chk("t5_found", {31'd0, found}, 32'd1);
    redirect_a(32'h300, 4, "t5");
    wait_drain(0, "t5_drain");

    // PC wrap at the top of the address space.
    gnt_rand_a = 1'b1;
    @(posedge clk); #1;
    redirect_a(32'hFFFF_FFFC, 4, "wrap");
    wait_drain(0, "wrap_drain");

    // 6: non-RVC instance, then reset in the middle of a stream.
    @(posedge clk); #1;
    rst_b = 1'b0;
    push_stream(1, 32'h40, 20, 1'b0);
    rdy_en_b = 1'b1;
    @(negedge clk);
    chk("t6_first_req",  {31'd0, bus_b.im_req_o}, 32'd1);
    chk("t6_first_addr", bus_b.im_addr_o, 32'h40);
    n = 0;
    while (exp_b.size() > 15 && n < 100) begin @(posedge clk); n++; end
    @(posedge clk); #1;
    rst_b = 1'b1;
    exp_b.delete();
    @(negedge clk);
    @(negedge clk);
    chk("t6_rst_pc",    bus_b.pc_o, 32'h40);
    chk("t6_rst_valid", {31'd0, bus_b.instr_valid_o}, 32'd0);
    chk("t6_rst_req",   {31'd0, bus_b.im_req_o}, 32'd0);
    @(posedge clk); #1;
    rst_b = 1'b0;
    push_stream(1, 32'h40, 4, 1'b0);
    wait_drain(1, "t6_drain");

    @(posedge clk); #1;
    redir_b = 1'b1;
    rpc_b   = 32'h302;
    exp_b.delete();
    push_stream(1, 32'h300, 3, 1'b0);
    @(posedge clk); #1;
    redir_b = 1'b0;
    @(negedge clk);
    chk("t6_redir_pc",   bus_b.pc_o, 32'h300);
    chk("t6_redir_addr", bus_b.im_addr_o, 32'h300);
    wait_drain(1, "t6_redir_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
